// File: rtl/distribuidor_papeis_pkg.sv
// Shared werewolf-game constants: role codes, dealer state codes and LFSR parameters.
// Used by the role dealer, the game controller and the display decoder.
package pacote_lobinho;

   localparam logic [1:0] ALDEAO  = 2'd0;
   localparam logic [1:0] LOBO    = 2'd1;
   localparam logic [1:0] VIDENTE = 2'd2;
   localparam logic [1:0] MEDICO  = 2'd3;

   typedef enum logic [4:0] {
      OCIOSO   = 5'd0,
      CARREGA  = 5'd1,
      PREENCHE = 5'd2,
      SORTEIA  = 5'd3,
      TROCA    = 5'd4,
      PRONTO   = 5'd5
   } estado_t;

   localparam logic [4:0]  ESTADO_ILEGAL = 5'b11111;
   localparam logic [15:0] LFSR_TAPS     = 16'hB400;
   localparam logic [15:0] SEMENTE_ZERO  = 16'hACE1;

   // One step of the right-shifting Galois LFSR.
   function automatic logic [15:0] passo_lfsr(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

   // Role placed at position k before shuffling.
   function automatic logic [1:0] papel_inicial(input int k, input int n_lobos);
      if (k < n_lobos)            return LOBO;
      else if (k == n_lobos)      return VIDENTE;
      else if (k == n_lobos + 1)  return MEDICO;
      else                        return ALDEAO;
   endfunction

endpackage

// File: rtl/distribuidor_papeis_lfsr16.sv
// 16-bit Galois LFSR used as the shuffle's random source.
// A zero load value is replaced by a fixed nonzero seed so the sequence never locks up.
module lfsr16
   import pacote_lobinho::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        carrega,
   input  logic [15:0] valor,
   input  logic        avanca,
   output logic [15:0] q
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         q <= SEMENTE_ZERO;
      else if (carrega)
         q <= (valor == 16'h0000) ? SEMENTE_ZERO : valor;
      else if (avanca)
         q <= passo_lfsr(q);
   end

endmodule

// File: rtl/distribuidor_papeis.sv
// Werewolf role dealer: fills a role table, then applies a seeded Fisher-Yates shuffle.
// The finished table stays readable through rd_addr/rd_papel until the next deal or reset.
module distribuidor_papeis
   import pacote_lobinho::*;
#(
   parameter int N_JOGADORES = 8,
   parameter int N_LOBOS     = 2
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           inicia,
   input  logic [15:0]                    seed,
   input  logic [$clog2(N_JOGADORES)-1:0] rd_addr,
   output logic [1:0]                     rd_papel,
   output logic                           ocupado,
   output logic                           pronto,
   output logic [4:0]                     db_estado
);

   localparam int          W       = $clog2(N_JOGADORES);
   localparam logic [W-1:0] ULTIMO = W'(N_JOGADORES - 1);
   localparam logic [15:0] MASCARA = 16'((1 << W) - 1);

   estado_t      estado;
   logic [W-1:0] k;
   logic [W-1:0] i;
   logic [1:0]   tabela [N_JOGADORES];

   logic [15:0]  lfsr_q;
   logic [15:0]  lfsr_prox;
   logic         aceita;
   logic         candidato_ok;
   logic [W-1:0] j;

   // A start pulse is only honoured when no deal is in progress.
   assign aceita = inicia && (estado == OCIOSO || estado == PRONTO);

   lfsr16 u_lfsr (
      .clock  (clock),
      .reset  (reset),
      .carrega(aceita),
      .valor  (seed),
      .avanca (estado == SORTEIA),
      .q      (lfsr_q)
   );

   // The candidate is judged on the value the LFSR takes after this cycle's step;
   // by TROCA that stepped value is sitting in the register.
   assign lfsr_prox    = passo_lfsr(lfsr_q);
   assign candidato_ok = (lfsr_prox & MASCARA) <= {{(16 - W){1'b0}}, i};
   assign j            = lfsr_q[W-1:0];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado <= OCIOSO;
         k      <= '0;
         i      <= '0;
         // NOTE: the role table is a register file, not a RAM, so it is cleared on
         // reset; a reset mid-deal must not leave a partial table visible.
         for (int n = 0; n < N_JOGADORES; n++)
            tabela[n] <= ALDEAO;
      end else begin
         case (estado)
            OCIOSO:  if (aceita) estado <= CARREGA;
            CARREGA: begin
               k      <= '0;
               estado <= PREENCHE;
            end
            PREENCHE: begin
               tabela[k] <= papel_inicial(int'(k), N_LOBOS);
               k         <= k + 1'b1;
               if (k == ULTIMO) begin
                  i      <= ULTIMO;
                  estado <= SORTEIA;
               end
            end
            SORTEIA: if (candidato_ok) estado <= TROCA;
            TROCA: begin
               // NOTE: both sides read the old table contents, which is what makes
               // this a one-cycle swap; blocking assignments here would corrupt it.
               tabela[i] <= tabela[j];
               tabela[j] <= tabela[i];
               if (i == W'(1)) begin
                  estado <= PRONTO;
               end else begin
                  i      <= i - 1'b1;
                  estado <= SORTEIA;
               end
            end
            PRONTO:  if (aceita) estado <= CARREGA;
            default: estado <= OCIOSO;
         endcase
      end
   end

   assign rd_papel  = tabela[rd_addr];
   assign ocupado   = estado inside {CARREGA, PREENCHE, SORTEIA, TROCA};
   assign pronto    = (estado == PRONTO);
   assign db_estado = (estado inside {OCIOSO, CARREGA, PREENCHE, SORTEIA, TROCA, PRONTO})
                      ? 5'(estado) : ESTADO_ILEGAL;

endmodule

// File: tb/tb_distribuidor_papeis.sv
// Directed bench for distribuidor_papeis (N=8, 2 wolves) against an independent
// shuffle model: reset, role counts, determinism, ignored start, mid-deal reset, re-deal.
module tb_distribuidor_papeis;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        inicia = 1'b0;
   logic [15:0] seed = 16'h0000;
   logic [2:0]  rd_addr = 3'd0;
   logic [1:0]  rd_papel;
   logic        ocupado;
   logic        pronto;
   logic [4:0]  db_estado;

   int passed = 0;
   int total  = 0;

   logic [1:0] ref_tab [8];
   int         ref_ciclos;

   distribuidor_papeis #(.N_JOGADORES(8), .N_LOBOS(2)) dut (
      .clock    (clock),
      .reset    (reset),
      .inicia   (inicia),
      .seed     (seed),
      .rd_addr  (rd_addr),
      .rd_papel (rd_papel),
      .ocupado  (ocupado),
      .pronto   (pronto),
      .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // Reference deal: fill, then Fisher-Yates with rejection on the low 3 LFSR bits.
   task automatic modelo(input logic [15:0] s);
      logic [15:0] l;
      logic [1:0]  t;
      logic        lb;
      int          jj;
      l = (s == 16'h0000) ? 16'hACE1 : s;
      for (int k = 0; k < 8; k++)
         ref_tab[k] = (k < 2) ? 2'd1 : (k == 2) ? 2'd2 : (k == 3) ? 2'd3 : 2'd0;
      ref_ciclos = 1 + 8;
      for (int ii = 7; ii >= 1; ii--) begin
         do begin
            lb = l[0];
            l  = l >> 1;
            if (lb) l = l ^ 16'hB400;
            ref_ciclos++;
            jj = int'(l & 16'h0007);
         end while (jj > ii);
         t           = ref_tab[ii];
         ref_tab[ii] = ref_tab[jj];
         ref_tab[jj] = t;
         ref_ciclos++;
      end
   endtask

   // Pulse inicia across one rising edge; returns at the following falling edge.
   task automatic dispara(input logic [15:0] s);
      @(negedge clock);
      inicia = 1'b1;
      seed   = s;
      @(negedge clock);
      inicia = 1'b0;
      seed   = ~s;
   endtask

   task automatic espera_pronto(input string tag, inout int n);
      while (!pronto && n < 2000) begin
         @(negedge clock);
         n++;
      end
      check({tag, "_pronto"}, pronto, 1'b1);
      check({tag, "_ciclos"}, n, ref_ciclos);
   endtask

   task automatic confere_tabela(input string tag);
      for (int a = 0; a < 8; a++) begin
         rd_addr = 3'(a);
         #1;
         check($sformatf("%s_papel%0d", tag, a), rd_papel, ref_tab[a]);
      end
   endtask

   task automatic conta_papeis(input string tag);
      int c [4];
      for (int r = 0; r < 4; r++) c[r] = 0;
      for (int a = 0; a < 8; a++) begin
         rd_addr = 3'(a);
         #1;
         c[rd_papel]++;
      end
      check({tag, "_aldeoes"}, c[0], 4);
      check({tag, "_lobos"},   c[1], 2);
      check({tag, "_videntes"}, c[2], 1);
      check({tag, "_medicos"}, c[3], 1);
   endtask

   task automatic confere_reset(input string tag);
      check({tag, "_pronto"},    pronto,    1'b0);
      check({tag, "_ocupado"},   ocupado,   1'b0);
      check({tag, "_db_estado"}, db_estado, 5'd0);
      for (int a = 0; a < 8; a++) begin
         rd_addr = 3'(a);
         #1;
         check($sformatf("%s_zero%0d", tag, a), rd_papel, 2'd0);
      end
   endtask

   initial begin
      int n;
      int vistos;

      // Reset
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      confere_reset("reset");

      // Role counts and model match, seed 0x1234
      modelo(16'h1234);
      dispara(16'h1234);
      n = 0;
      espera_pronto("s1234", n);
      conta_papeis("s1234");
      confere_tabela("s1234");

      // Determinism: seed 0xBEEF twice
      modelo(16'hBEEF);
      for (int r = 0; r < 2; r++) begin
         dispara(16'hBEEF);
         n = 0;
         espera_pronto($sformatf("beef%0d", r), n);
         confere_tabela($sformatf("beef%0d", r));
      end

      // Zero seed behaves as 0xACE1
      modelo(16'hACE1);
      dispara(16'h0000);
      n = 0;
      espera_pronto("zero", n);
      confere_tabela("zero");

      // Start pulse during SORTEIA is ignored
      modelo(16'h1234);
      dispara(16'h1234);
      n = 0;
      while (db_estado != 5'd3 && n < 2000) begin
         @(negedge clock);
         n++;
      end
      check("ign_sorteia", db_estado, 5'd3);
      inicia = 1'b1;
      seed   = 16'h5555;
      @(negedge clock);
      n++;
      inicia = 1'b0;
      check("ign_ocupado", ocupado, 1'b1);
      espera_pronto("ign", n);
      confere_tabela("ign");

      // Reset in TROCA with i=4 (the fourth swap cycle)
      dispara(16'h1234);
      vistos = 0;
      n = 0;
      while (n < 2000) begin
         if (db_estado == 5'd4) begin
            vistos++;
            if (vistos == 4) break;
         end
         @(negedge clock);
         n++;
      end
      check("rst_troca_i4", vistos, 4);
      reset = 1'b1;
      #1;
      confere_reset("rst_meio");
      @(negedge clock);
      reset = 1'b0;
      modelo(16'h1234);
      dispara(16'h1234);
      n = 0;
      espera_pronto("pos_rst", n);
      confere_tabela("pos_rst");

      // Re-deal from PRONTO
      modelo(16'h00FF);
      dispara(16'h00FF);
      check("redeal_pronto_cai", pronto, 1'b0);
      check("redeal_carrega", db_estado, 5'd1);
      n = 0;
      espera_pronto("redeal", n);
      confere_tabela("redeal");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
